psl_sync_fifo_sa: RTL and testbench

//  Parametrised show-ahead synchronous FIFO, next generation of the DMA datapath FIFO.

---
 rtl/psl_fifo_pkg.sv | 16 +
 rtl/psl_fifo_ram.sv | 34 +++
 rtl/psl_sync_fifo_sa.sv | 169 ++++++++++++++++
 tb/tb_psl_sync_fifo_sa.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/psl_fifo_pkg.sv
// Shared types, sizes and the parity helper for the PSL show-ahead FIFO family.
package psl_fifo_pkg;

    localparam int FIFO_AW   = 3;
    localparam int FIFO_DW   = 8;
    localparam int DEPTH     = 2 ** FIFO_AW;
    localparam int PAR_MAX_W = 64;

    typedef logic [FIFO_AW:0] fifo_cnt_t;

    // Even parity bit: storing it alongside the data makes the XOR of the whole word zero.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/psl_fifo_ram.sv
// Single-write / single-read word array with a registered read address and an async array read.
module psl_fifo_ram #(
    parameter int AW = 3,
    parameter int W  = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] rd_addr_reg;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_addr_reg <= '0;
        end else begin
            rd_addr_reg <= rd_addr;
        end
    end

    assign rd_data = mem[rd_addr_reg];

endmodule

// File: rtl/psl_sync_fifo_sa.sv
// Show-ahead synchronous FIFO with guarded push/pop, programmable thresholds and sticky errors.
// Define SYNC_FIFO_PARITY_EN to store an even-parity bit per word and report perr_o on pops.
module psl_sync_fifo_sa
    import psl_fifo_pkg::*;
#(
    parameter int AW        = 3,
    parameter int DW        = 8,
    parameter int AFULL_RST = 6
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          w_en_i,
    input  logic [DW-1:0] w_din_i,
    output logic [AW:0]   w_num_used_o,
    output logic          full_o,
    output logic          afull_o,
    input  logic [AW:0]   afull_thr_i,
    input  logic          r_en_i,
    output logic [DW-1:0] r_dout_o,
    output logic [AW:0]   r_num_val_o,
    output logic          empty_o,
    output logic          aempty_o,
    input  logic [AW:0]   aempty_thr_i,
    output logic          ovf_o,
    output logic          udf_o,
    input  logic          clr_err_i,
    output logic          perr_o
);

`ifdef SYNC_FIFO_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    localparam logic [AW:0]   FULL_CNT  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   AFULL_DEF = (AW+1)'(AFULL_RST);

    logic          w_acc;
    logic          r_acc;
    logic [AW-1:0] waddr_reg, waddr_next;
    logic [AW-1:0] raddr_reg, raddr_next;
    logic [AW:0]   used_reg, used_next;
    logic [AW:0]   val_reg, val_next;
    logic          w_acc_d_reg;
    logic          full_reg, full_next;
    logic          afull_reg, afull_next;
    logic          empty_reg, empty_next;
    logic          aempty_reg, aempty_next;
    logic          ovf_reg, ovf_next;
    logic          udf_reg, udf_next;
    logic [AW:0]   afull_thr_eff;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;

    assign w_acc = w_en_i & ~full_reg;
    assign r_acc = r_en_i & ~empty_reg;

    assign afull_thr_eff = (afull_thr_i == '0) ? AFULL_DEF : afull_thr_i;

    always_comb begin
        waddr_next = waddr_reg;
        raddr_next = raddr_reg;
        used_next  = used_reg;
        val_next   = val_reg;

        if (w_acc) begin
            waddr_next = waddr_reg + PTR_ONE;
        end
        // The read address is looked ahead so the next word is already on r_dout_o after a pop.
        if (r_acc) begin
            raddr_next = raddr_reg + PTR_ONE;
        end

        case ({w_acc, r_acc})
            2'b10:   used_next = used_reg + CNT_ONE;
            2'b01:   used_next = used_reg - CNT_ONE;
            default: used_next = used_reg;
        endcase

        // Readable count trails the allocated count by one cycle to cover the array write.
        case ({w_acc_d_reg, r_acc})
            2'b10:   val_next = val_reg + CNT_ONE;
            2'b01:   val_next = val_reg - CNT_ONE;
            default: val_next = val_reg;
        endcase

        full_next   = (used_next == FULL_CNT);
        afull_next  = (used_next >= afull_thr_eff);
        empty_next  = (val_next == '0);
        aempty_next = (val_next <= aempty_thr_i);

        ovf_next = (w_en_i & full_reg)  | (ovf_reg & ~clr_err_i);
        udf_next = (r_en_i & empty_reg) | (udf_reg & ~clr_err_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            waddr_reg   <= '0;
            raddr_reg   <= '0;
            used_reg    <= '0;
            val_reg     <= '0;
            w_acc_d_reg <= 1'b0;
            full_reg    <= 1'b0;
            afull_reg   <= 1'b0;
            empty_reg   <= 1'b1;
            aempty_reg  <= 1'b1;
            ovf_reg     <= 1'b0;
            udf_reg     <= 1'b0;
        end else begin
            waddr_reg   <= waddr_next;
            raddr_reg   <= raddr_next;
            used_reg    <= used_next;
            val_reg     <= val_next;
            w_acc_d_reg <= w_acc;
            full_reg    <= full_next;
            afull_reg   <= afull_next;
            empty_reg   <= empty_next;
            aempty_reg  <= aempty_next;
            ovf_reg     <= ovf_next;
            udf_reg     <= udf_next;
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    logic perr_reg;

    assign wr_word = {even_parity(PAR_MAX_W'(w_din_i)), w_din_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perr_reg <= 1'b0;
        end else begin
            perr_reg <= r_acc & (^rd_word);
        end
    end

    assign perr_o = perr_reg;
`else
    assign wr_word = w_din_i;
    assign perr_o  = 1'b0;
`endif

    psl_fifo_ram #(
        .AW (AW),
        .W  (MW)
    ) u_ram (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .wr_en   (w_acc),
        .wr_addr (waddr_reg),
        .wr_data (wr_word),
        .rd_addr (raddr_next),
        .rd_data (rd_word)
    );

    assign r_dout_o     = rd_word[DW-1:0];
    assign w_num_used_o = used_reg;
    assign r_num_val_o  = val_reg;
    assign full_o       = full_reg;
    assign afull_o      = afull_reg;
    assign empty_o      = empty_reg;
    assign aempty_o     = aempty_reg;
    assign ovf_o        = ovf_reg;
    assign udf_o        = udf_reg;

endmodule

// File: tb/tb_psl_sync_fifo_sa.sv
// Directed scoreboard bench for psl_sync_fifo_sa (AW=3, DW=8, AFULL_RST=6).
module tb_psl_sync_fifo_sa;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          w_en_i;
    logic [DW-1:0] w_din_i;
    logic [AW:0]   w_num_used_o;
    logic          full_o;
    logic          afull_o;
    logic [AW:0]   afull_thr_i;
    logic          r_en_i;
    logic [DW-1:0] r_dout_o;
    logic [AW:0]   r_num_val_o;
    logic          empty_o;
    logic          aempty_o;
    logic [AW:0]   aempty_thr_i;
    logic          ovf_o;
    logic          udf_o;
    logic          clr_err_i;
    logic          perr_o;

    int            checks = 0;
    int            errors = 0;
    int            pops   = 0;
    int            exp_pops = 30;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_exp;

    always #5 clk_i = ~clk_i;

    psl_sync_fifo_sa #(
        .AW        (AW),
        .DW        (DW),
        .AFULL_RST (6)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .w_en_i       (w_en_i),
        .w_din_i      (w_din_i),
        .w_num_used_o (w_num_used_o),
        .full_o       (full_o),
        .afull_o      (afull_o),
        .afull_thr_i  (afull_thr_i),
        .r_en_i       (r_en_i),
        .r_dout_o     (r_dout_o),
        .r_num_val_o  (r_num_val_o),
        .empty_o      (empty_o),
        .aempty_o     (aempty_o),
        .aempty_thr_i (aempty_thr_i),
        .ovf_o        (ovf_o),
        .udf_o        (udf_o),
        .clr_err_i    (clr_err_i),
        .perr_o       (perr_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected word.
    always @(negedge clk_i) begin
        if (!reset_i && r_en_i && !empty_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no pop", r_dout_o);
            end else begin
                mon_exp = exp_q.pop_front();
                pops++;
                $display("pop  #%0d data=0x%0h exp=0x%0h", pops, r_dout_o, mon_exp);
                chk("pop_data", 32'(r_dout_o), 32'(mon_exp));
            end
        end
    end

    // One clock of stimulus; wexp marks a write the bench expects the FIFO to accept.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic wexp);
        w_en_i  = w;
        w_din_i = d;
        r_en_i  = r;
        if (w && wexp) exp_q.push_back(d);
        if (w) $display("push data=0x%0h expect_accept=%0d", d, wexp);
        @(posedge clk_i);
        #1;
        w_en_i    = 1'b0;
        r_en_i    = 1'b0;
        clr_err_i = 1'b0;
    endtask

    initial begin
        reset_i      = 1'b1;
        w_en_i       = 1'b0;
        w_din_i      = '0;
        r_en_i       = 1'b0;
        clr_err_i    = 1'b0;
        afull_thr_i  = '0;
        aempty_thr_i = 4'd1;
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        reset_i = 1'b0;

        chk("rst_empty",  32'(empty_o), 1);
        chk("rst_aempty", 32'(aempty_o), 1);
        chk("rst_full",   32'(full_o), 0);
        chk("rst_afull",  32'(afull_o), 0);
        chk("rst_ovf",    32'(ovf_o), 0);
        chk("rst_udf",    32'(udf_o), 0);
        chk("rst_perr",   32'(perr_o), 0);
        chk("rst_used",   32'(w_num_used_o), 0);
        chk("rst_val",    32'(r_num_val_o), 0);

        // Write latency: word written in cycle 0 is readable in cycle 2.
        cyc(1, 8'hA5, 0, 1);
        chk("lat_c1_empty", 32'(empty_o), 1);
        chk("lat_c1_used",  32'(w_num_used_o), 1);
        chk("lat_c1_val",   32'(r_num_val_o), 0);
        cyc(0, 8'h00, 0, 0);
        chk("lat_c2_empty", 32'(empty_o), 0);
        chk("lat_c2_val",   32'(r_num_val_o), 1);
        chk("lat_c2_dout",  32'(r_dout_o), 32'hA5);
        cyc(0, 8'h00, 1, 0);
        chk("lat_pop_empty", 32'(empty_o), 1);
        chk("lat_pop_used",  32'(w_num_used_o), 0);

        // Fill to full with the default almost-full threshold (6).
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'(8'h10 + i), 0, 1);
            chk("fill_used",  32'(w_num_used_o), 32'(i + 1));
            chk("fill_afull", 32'(afull_o), (i >= 5) ? 1 : 0);
            chk("fill_full",  32'(full_o), (i == 7) ? 1 : 0);
        end
        cyc(1, 8'hFF, 0, 0);
        chk("ovf_set",  32'(ovf_o), 1);
        chk("ovf_used", 32'(w_num_used_o), 8);
        chk("ovf_full", 32'(full_o), 1);
        chk("ovf_val",  32'(r_num_val_o), 8);

        // Full with push and pop together: pop wins, push is dropped.
        cyc(1, 8'hEE, 1, 0);
        chk("fullrw_used", 32'(w_num_used_o), 7);
        chk("fullrw_full", 32'(full_o), 0);
        chk("fullrw_ovf",  32'(ovf_o), 1);
        chk("fullrw_val",  32'(r_num_val_o), 7);
        clr_err_i = 1'b1;
        cyc(0, 8'h00, 0, 0);
        chk("ovf_clr", 32'(ovf_o), 0);

        cyc(0, 8'h00, 1, 0);
        chk("afull_at6", 32'(afull_o), 1);
        cyc(0, 8'h00, 1, 0);
        chk("afull_at5", 32'(afull_o), 0);
        chk("used_at5",  32'(w_num_used_o), 5);
        afull_thr_i = 4'd4;
        cyc(0, 8'h00, 0, 0);
        chk("afull_thr4", 32'(afull_o), 1);
        afull_thr_i = 4'd0;
        cyc(0, 8'h00, 0, 0);
        chk("afull_thr0", 32'(afull_o), 0);

        // Drain the remaining five words, watching almost-empty at threshold 1.
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 8'h00, 1, 0);
            chk("drain_val",    32'(r_num_val_o), 32'(5 - k));
            chk("drain_aempty", 32'(aempty_o), (k >= 4) ? 1 : 0);
            chk("drain_empty",  32'(empty_o), (k == 5) ? 1 : 0);
        end

        // Underflow, clear, and set-over-clear priority.
        cyc(0, 8'h00, 1, 0);
        chk("udf_set", 32'(udf_o), 1);
        chk("udf_val", 32'(r_num_val_o), 0);
        clr_err_i = 1'b1;
        cyc(0, 8'h00, 0, 0);
        chk("udf_clr", 32'(udf_o), 0);
        clr_err_i = 1'b1;
        cyc(0, 8'h00, 1, 0);
        chk("udf_set_prio", 32'(udf_o), 1);
        clr_err_i = 1'b1;
        cyc(0, 8'h00, 0, 0);
        chk("udf_clr2", 32'(udf_o), 0);

        // Pop one cycle after a push: still empty, so rejected while the count rises.
        cyc(1, 8'h42, 0, 1);
        cyc(0, 8'h00, 1, 0);
        chk("emptyw_udf",   32'(udf_o), 1);
        chk("emptyw_val",   32'(r_num_val_o), 1);
        chk("emptyw_empty", 32'(empty_o), 0);
        chk("emptyw_used",  32'(w_num_used_o), 1);
        clr_err_i = 1'b1;
        cyc(0, 8'h00, 1, 0);
        chk("emptyw_udf_clr", 32'(udf_o), 0);
        chk("emptyw_used0",   32'(w_num_used_o), 0);

        // Streaming: 20 words, push and pop every cycle across the pointer wrap.
        for (int i = 0; i < 22; i++) begin
            cyc((i < 20) ? 1'b1 : 1'b0, 8'(i * 13 + 5), (i >= 2) ? 1'b1 : 1'b0, 1'b1);
            chk("strm_val",   32'(r_num_val_o), (i >= 1 && i <= 20) ? 1 : 0);
            chk("strm_empty", 32'(empty_o),     (i >= 1 && i <= 20) ? 0 : 1);
            chk("strm_used",  32'(w_num_used_o), (i == 0 || i == 20) ? 1 : ((i == 21) ? 0 : 2));
            chk("strm_perr",  32'(perr_o), 0);
        end

`ifdef SYNC_FIFO_PARITY_EN
        begin
            logic [AW-1:0] inj_addr;
            inj_addr = dut.waddr_reg;
            cyc(1, 8'h3C, 0, 1);
            cyc(0, 8'h00, 0, 0);
            dut.u_ram.mem[inj_addr][DW] = ~dut.u_ram.mem[inj_addr][DW];
            cyc(0, 8'h00, 1, 0);
            chk("perr_pulse", 32'(perr_o), 1);
            cyc(0, 8'h00, 0, 0);
            chk("perr_clear", 32'(perr_o), 0);
            exp_pops = exp_pops + 1;
        end
`endif

        chk("pops_total", 32'(pops), 32'(exp_pops));
        chk("queue_left", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
